// File: rtl/display_sched_pkg.sv
// Shared types and constants for the display source scheduler.
// Contents:
//   sched_state_e - scheduler FSM states (active, pending switch, blanking)
//   COLOR_BLACK   - colour value driven while blanking or when a source is not ready
package display_sched_pkg;

    typedef enum logic [1:0] {
        StActive  = 2'd0,
        StPending = 2'd1,
        StBlank   = 2'd2
    } sched_state_e;

    localparam int unsigned COLOR_BLACK = 0;

endpackage

// File: rtl/display_source_scheduler_if.sv
// Pixel-source bus between the function containers, the scheduler and the VGA stage.
// Signals:
//   src_ready     - bit i high when source i has valid content
//   src_color     - flattened source colours, source i at [i*COLOR_W +: COLOR_W]
//   display_color - registered colour towards the VGA output stage
//   active_src    - index of the committed source
//   switching     - a source switch is pending or blanking
//   switch_done   - one-cycle pulse when a new active_src is committed
// Modports: master drives the sources and observes the result, slave is the scheduler.
interface display_source_scheduler_if #(
    parameter int unsigned NUM_SRC = 2,
    parameter int unsigned COLOR_W = 3
);
    localparam int unsigned SRC_W = $clog2(NUM_SRC);

    logic [NUM_SRC-1:0]         src_ready;
    logic [NUM_SRC*COLOR_W-1:0] src_color;
    logic [COLOR_W-1:0]         display_color;
    logic [SRC_W-1:0]           active_src;
    logic                       switching;
    logic                       switch_done;

    modport master (
        output src_ready, src_color,
        input  display_color, active_src, switching, switch_done
    );

    modport slave (
        input  src_ready, src_color,
        output display_color, active_src, switching, switch_done
    );

endinterface

// File: rtl/button_debouncer.sv
// Two-flop synchroniser plus debouncer for a raw push button.
// Ports:
//   sysclk - system clock
//   rst_n  - asynchronous active-low reset
//   button - raw asynchronous button level, active-high
//   press  - one-cycle pulse on a 0->1 edge of the debounced level
// The debounced level flips only after the synchronised input has disagreed with it
// for DEBOUNCE_CYCLES consecutive cycles; any agreement restarts the count.
module button_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic sysclk,
    input  logic rst_n,
    input  logic button,
    output logic press
);
    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    logic             level_q, level_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_q, press_d;

    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        press_d = 1'b0;
        if (sync_q[1] == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            // This is the DEBOUNCE_CYCLES-th consecutive disagreeing cycle.
            level_d = sync_q[1];
            cnt_d   = '0;
            press_d = sync_q[1];
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= 2'b00;
            level_q <= 1'b0;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], button};
            level_q <= level_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/display_source_scheduler.sv
// Frame-synchronous pixel source scheduler. A debounced button press requests a switch to
// the next ready source; the switch waits for a frame boundary, inserts BLANK_FRAMES black
// frames and commits on a frame boundary, so the output never tears mid-frame.
// Ports:
//   sysclk        - system clock
//   rst_n         - asynchronous active-low reset
//   change_button - raw source-change push button
//   frame_start   - one-cycle pulse at start of vertical blank
//   bus           - pixel-source bus (slave side): source inputs, colour and status outputs
module display_source_scheduler
    import display_sched_pkg::*;
#(
    parameter int unsigned NUM_SRC         = 2,
    parameter int unsigned COLOR_W         = 3,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned BLANK_FRAMES    = 1
) (
    input  logic                      sysclk,
    input  logic                      rst_n,
    input  logic                      change_button,
    input  logic                      frame_start,
    display_source_scheduler_if.slave bus
);
    localparam int unsigned SRC_W = $clog2(NUM_SRC);
    localparam int unsigned BCNT_W = $clog2(BLANK_FRAMES + 1);
    localparam logic [COLOR_W-1:0] BLACK = COLOR_W'(COLOR_BLACK);

    // First ready source after cur in round-robin order; cur itself if none is ready.
    function automatic logic [SRC_W-1:0] next_ready(input logic [SRC_W-1:0] cur,
                                                    input logic [NUM_SRC-1:0] ready);
        logic [SRC_W-1:0] sel;
        logic             found;
        int unsigned      idx;
        sel   = cur;
        found = 1'b0;
        for (int unsigned k = 1; k < NUM_SRC; k++) begin
            idx = (32'(cur) + k) % NUM_SRC;
            if (!found && ready[SRC_W'(idx)]) begin
                sel   = SRC_W'(idx);
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    sched_state_e      state_q, state_d;
    logic [BCNT_W-1:0] blank_cnt_q, blank_cnt_d;
    logic              queued_q, queued_d;
    logic [SRC_W-1:0]  active_src_q, active_src_d;
    logic [COLOR_W-1:0] color_q, color_d;
    logic              switch_done_q, switch_done_d;
    logic              press;
    logic [COLOR_W-1:0] cur_color;

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
        .sysclk(sysclk),
        .rst_n (rst_n),
        .button(change_button),
        .press (press)
    );

    assign cur_color = COLOR_W'(bus.src_color >> (active_src_q * COLOR_W));

    always_comb begin
        state_d       = state_q;
        blank_cnt_d   = blank_cnt_q;
        queued_d      = queued_q;
        active_src_d  = active_src_q;
        color_d       = color_q;
        switch_done_d = 1'b0;
        unique case (state_q)
            StActive: begin
                color_d = bus.src_ready[active_src_q] ? cur_color : BLACK;
                // A concurrent frame_start is deliberately ignored here.
                if (press) state_d = StPending;
            end
            StPending: begin
                if (press) queued_d = 1'b1;
                if (frame_start) begin
                    state_d     = StBlank;
                    blank_cnt_d = '0;
                end
            end
            StBlank: begin
                color_d = BLACK;
                if (press) queued_d = 1'b1;
                if (frame_start) begin
                    blank_cnt_d = blank_cnt_q + BCNT_W'(1);
                    if ((32'(blank_cnt_q) + 32'd1) == BLANK_FRAMES) begin
                        active_src_d  = next_ready(active_src_q, bus.src_ready);
                        switch_done_d = 1'b1;
                        blank_cnt_d   = '0;
                        // A press landing on the commit cycle counts as queued.
                        if (queued_q || press) begin
                            state_d  = StPending;
                            queued_d = 1'b0;
                        end else begin
                            state_d = StActive;
                        end
                    end
                end
            end
            default: state_d = StActive;
        endcase
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StActive;
            blank_cnt_q   <= '0;
            queued_q      <= 1'b0;
            active_src_q  <= '0;
            color_q       <= BLACK;
            switch_done_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            blank_cnt_q   <= blank_cnt_d;
            queued_q      <= queued_d;
            active_src_q  <= active_src_d;
            color_q       <= color_d;
            switch_done_q <= switch_done_d;
        end
    end

    assign bus.display_color = color_q;
    assign bus.active_src    = active_src_q;
    assign bus.switching     = (state_q != StActive);
    assign bus.switch_done   = switch_done_q;

endmodule
